// File: rtl/fb_cpu_ext.sv
// Accumulator CPU with a five-state fetch/decode/execute controller driving a
// synchronous-read RAM.
//   state    | meaning
//   S_FETCH  | present PC on MAR
//   S_DECODE | latch IR from RAM, PC += 1
//   S_EXEC   | jumps, LOADI, STORE, HALT; memory-operand ops present X on MAR
//   S_MEM    | combine RAM data into ACC/carry
//   S_HALT   | absorbing until rst
module fb_cpu_ext #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    MDROut,
  output logic [ADDRESS_WIDTH-1:0] MAR,
  output logic                     RAMWr,
  output logic [DATA_WIDTH-1:0]    MDRIn,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0]    ACC,
  output logic                     carry,
  output logic                     zero,
  output logic                     halted
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_MUL   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_LOADI = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'h9;
  localparam logic [3:0] OP_OR    = 4'hA;
  localparam logic [3:0] OP_XOR   = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_JC    = 4'hD;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            carry_q, carry_d;

  logic [3:0]      opcode;
  logic [AW-1:0]   x;
  logic [DW:0]     sum;
  logic [DW:0]     diff;
  logic [2*DW-1:0] prod;

  assign opcode = ir_q[DW-1:DW-4];
  assign x      = ir_q[AW-1:0];
  assign sum    = {1'b0, acc_q} + {1'b0, MDROut};
  assign diff   = {1'b0, acc_q} - {1'b0, MDROut};
  assign prod   = {{DW{1'b0}}, acc_q} * {{DW{1'b0}}, MDROut};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    MAR     = '0;
    RAMWr   = 1'b0;
    MDRIn   = '0;
    case (state_q)
      S_FETCH: begin
        MAR     = pc_q;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = MDROut;
        pc_d    = pc_q + AW'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
            MAR     = x;
            state_d = S_MEM;
          end
          OP_STORE: begin
            MAR   = x;
            MDRIn = acc_q;
            RAMWr = 1'b1;
          end
          OP_JMP:   pc_d = x;
          OP_JZ:    if (acc_q == '0) pc_d = x;
          OP_JNZ:   if (acc_q != '0) pc_d = x;
          OP_JC:    if (carry_q) pc_d = x;
          OP_LOADI: acc_d = {{(DW-AW){1'b0}}, x};
          OP_HALT:  state_d = S_HALT;
          default:  ;
        endcase
      end
      S_MEM: begin
        state_d = S_FETCH;
        case (opcode)
          OP_LOAD: acc_d = MDROut;
          OP_ADD: begin
            acc_d   = sum[DW-1:0];
            carry_d = sum[DW];
          end
          OP_SUB: begin
            acc_d   = diff[DW-1:0];
            carry_d = diff[DW];
          end
          OP_MUL: begin
            acc_d   = prod[DW-1:0];
            carry_d = |prod[2*DW-1:DW];
          end
          OP_AND: begin
            acc_d   = acc_q & MDROut;
            carry_d = 1'b0;
          end
          OP_OR: begin
            acc_d   = acc_q | MDROut;
            carry_d = 1'b0;
          end
          OP_XOR: begin
            acc_d   = acc_q ^ MDROut;
            carry_d = 1'b0;
          end
          default: ;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Bus is quiet for the whole reset pulse, so a STORE caught mid-cycle never writes.
    if (rst) begin
      MAR   = '0;
      RAMWr = 1'b0;
      MDRIn = '0;
    end
  end

  assign PC     = pc_q;
  assign ACC    = acc_q;
  assign carry  = carry_q;
  assign zero   = (acc_q == '0);
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_fb_cpu_ext.sv
// Scoreboarded bench for fb_cpu_ext: an instruction-level model predicts retire
// snapshots and RAM writes; a negedge monitor compares them against the DUT.
module tb_fb_cpu_ext;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] MDROut;
  logic [5:0] MAR;
  logic       RAMWr;
  logic [9:0] MDRIn;
  logic [5:0] PC;
  logic [9:0] ACC;
  logic       carry, zero, halted;

  fb_cpu_ext #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .MDROut(MDROut), .MAR(MAR), .RAMWr(RAMWr),
    .MDRIn(MDRIn), .PC(PC), .ACC(ACC), .carry(carry), .zero(zero), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [9:0] mem [64];
  always @(posedge clk) begin
    if (RAMWr) mem[MAR] <= MDRIn;
    MDROut <= mem[MAR];
  end

  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {int cyc; int pc; int acc; int c; int h;} exp_t;
  typedef struct {int addr; int data; int cyc;} wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: RAM writes and instruction-retire snapshots
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (RAMWr) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d at cyc %0d, expected no write", MAR, MDRIn, cyc);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (MAR != w.addr || MDRIn != w.data || cyc != w.cyc) begin
            failures++;
            $display("FAIL write: got addr=%0d data=%0d cyc=%0d, expected addr=%0d data=%0d cyc=%0d",
                     MAR, MDRIn, cyc, w.addr, w.data, w.cyc);
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (PC != e.pc || ACC != e.acc || carry != e.c || zero != (e.acc == 0) || halted != e.h) begin
          failures++;
          $display("FAIL retire@%0d: got pc=%0d acc=%0d c=%0d z=%0d h=%0d, expected pc=%0d acc=%0d c=%0d z=%0d h=%0d",
                   cyc, PC, ACC, carry, zero, halted, e.pc, e.acc, e.c, (e.acc == 0), e.h);
        end
      end
    end
  end

  function automatic int enc(input int op, input int x);
    return op * 64 + x;
  endfunction

  // Instruction-level reference model over a private copy of memory
  task automatic run_model(input int max_cyc);
    int m [64];
    int pc, acc, c, t, ir, op, x, lat, v;
    for (int i = 0; i < 64; i++) m[i] = mem[i];
    pc = 0; acc = 0; c = 0; t = 0;
    while (1) begin
      ir  = m[pc];
      op  = ir / 64;
      x   = ir % 64;
      lat = (op inside {0, 2, 3, 4, 5, 10, 11}) ? 4 : 3;
      if (t + lat > max_cyc) break;
      pc = (pc + 1) % 64;
      v  = m[x];
      case (op)
        0:  acc = v;
        1:  begin m[x] = acc; wr_q.push_back('{x, acc, t + 2}); end
        2:  begin acc = acc + v; c = (acc >= 1024); acc = acc % 1024; end
        3:  begin c = (acc < v); acc = (acc - v + 1024) % 1024; end
        4:  begin acc = acc * v; c = (acc >= 1024); acc = acc % 1024; end
        5:  begin acc = acc & v; c = 0; end
        6:  pc = x;
        7:  if (acc == 0) pc = x;
        8:  acc = x;
        10: begin acc = acc | v; c = 0; end
        11: begin acc = acc ^ v; c = 0; end
        12: if (acc != 0) pc = x;
        13: if (c != 0) pc = x;
        default: ;
      endcase
      t = t + lat;
      exp_q.push_back('{t, pc, acc, c, (op == 9)});
      if (op == 9) break;
    end
  endtask

  task automatic hold_reset();
    mon_en = 0;
    rst = 1'b1;
    #2;
    check("rst_pc", PC, 0);
    check("rst_acc_c_h", {ACC, carry, halted}, 0);
    check("rst_bus", {MAR, RAMWr, MDRIn}, 0);
    exp_q.delete();
    wr_q.delete();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  task automatic launch(input int max_cyc);
    run_model(max_cyc);
    @(negedge clk);
    mon_en = 1;
    rst = 1'b0;
  endtask

  task automatic finish_run(input int max_cyc);
    for (int k = 0; k < max_cyc + 4 && cyc < max_cyc; k++) @(negedge clk);
    @(negedge clk);
    mon_en = 0;
    check("exp_q_drained", exp_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
  endtask

  task automatic basic_prog(input int op2, input int a, input int b);
    hold_reset();
    mem[0] = enc(0, 50); mem[1] = enc(op2, 51); mem[2] = enc(1, 52); mem[3] = enc(9, 0);
    mem[50] = a; mem[51] = b;
    launch(20);
    finish_run(20);
  endtask

  initial begin
    // Reference program: LOAD/ADD/STORE/HALT
    basic_prog(2, 5, 10);
    check("p1_mem52", mem[52], 15);
    check("p1_pc", PC, 4);
    check("p1_halted", halted, 1);

    basic_prog(4, 5, 10);
    check("mul_small_mem52", mem[52], 50);
    check("mul_small_carry", carry, 0);
    basic_prog(4, 40, 30);
    check("mul_ovf_mem52", mem[52], 176);
    check("mul_ovf_carry", carry, 1);

    // LOADI / ADD overflow / JC / SUB to zero / JNZ fall-through
    hold_reset();
    mem[0] = enc(8, 63); mem[1] = enc(2, 10); mem[2] = enc(13, 20);
    mem[20] = enc(3, 11); mem[21] = enc(12, 5); mem[22] = enc(9, 0);
    mem[10] = 1023; mem[11] = 62;
    launch(24);
    finish_run(24);
    check("flags_acc", ACC, 0);
    check("flags_zero_carry", {zero, carry}, 2);
    check("flags_pc", PC, 23);

    // PC wrap through a NOP at the top of memory
    hold_reset();
    mem[0] = enc(6, 63); mem[63] = enc(14, 0);
    launch(30);
    for (int k = 0; k < 10 && cyc < 3; k++) @(negedge clk);
    check("wrap_mar63", MAR, 63);
    for (int k = 0; k < 10 && cyc < 6; k++) @(negedge clk);
    check("wrap_mar0", MAR, 0);
    check("wrap_pc0", PC, 0);
    finish_run(30);

    // Reset landing in the STORE execute cycle
    hold_reset();
    mem[0] = enc(8, 5); mem[1] = enc(1, 40); mem[2] = enc(9, 0); mem[40] = 7;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_pre_wr", RAMWr, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_wr_low", RAMWr, 0);
    check("abort_state", {PC, ACC, halted}, 0);
    @(posedge clk);
    #1;
    check("abort_mem40", mem[40], 7);
    exp_q.delete();
    wr_q.delete();
    launch(20);
    finish_run(20);
    check("restart_mem40", mem[40], 5);
    check("restart_halted", halted, 1);

    // Randomized programs against the model
    for (int p = 0; p < 12; p++) begin
      hold_reset();
      for (int i = 0; i < 64; i++) begin
        int op;
        op = $urandom_range(0, 15);
        if (op == 9 && $urandom_range(0, 3) != 0) op = 14;
        mem[i] = (i >= 48 && $urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 1023))
                                                       : 10'(enc(op, $urandom_range(0, 63)));
      end
      launch(160);
      finish_run(160);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_cpu_ext.md
FB_CPU_EXT -- requirements
Module: fb_cpu_ext

Interface
REQ-001 ADDRESS_WIDTH, default 6, width of memory address, PC and instruction operand field.
REQ-002 DATA_WIDTH, default 10, width of memory word, IR and ACC; SHALL be >= ADDRESS_WIDTH+4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 MDROut  input  DATA_WIDTH  RAM read data, valid one cycle after MAR is presented (synchronous-read RAM).
REQ-006 MAR  output  ADDRESS_WIDTH  RAM address, combinational from state/PC/IR.
REQ-007 RAMWr  output  1  RAM write enable, combinational, sampled by RAM on rising edge.
REQ-008 MDRIn  output  DATA_WIDTH  RAM write data, combinational.
REQ-009 PC  output  ADDRESS_WIDTH  program counter.
REQ-010 ACC  output  DATA_WIDTH  accumulator.
REQ-011 carry  output  1  carry/borrow/overflow flag.
REQ-012 zero  output  1  high when ACC == 0 (combinational from ACC).
REQ-013 halted  output  1  high while in HALT state.

Function
REQ-014 Instruction format: opcode = IR[DATA_WIDTH-1:DATA_WIDTH-4], operand X = IR[ADDRESS_WIDTH-1:0]; bits between unused.
REQ-015 States: FETCH, DECODE, EXEC, MEM, HALT; encoding free.
REQ-016 FETCH: MAR=PC, RAMWr=0 -> DECODE.
REQ-017 DECODE: IR<=MDROut, PC<=PC+1 modulo 2^ADDRESS_WIDTH (63 wraps to 0 at default) -> EXEC.
REQ-018 EXEC, memory-operand ops (LOAD 0, ADD 2, SUB 3, MUL 4, AND 5, OR A, XOR B): MAR=X -> MEM.
REQ-019 MEM: LOAD ACC<=MDROut; ADD ACC<=ACC+MDROut, carry<=bit DATA_WIDTH of sum; SUB ACC<=ACC-MDROut, carry<=borrow (ACC<MDROut); MUL ACC<=low DATA_WIDTH bits of product, carry<=1 iff any upper product bit set; AND/OR/XOR bitwise, carry<=0; LOAD leaves carry unchanged -> FETCH.
REQ-020 EXEC STORE (1): MAR=X, MDRIn=ACC, RAMWr=1 for exactly this one cycle -> FETCH.
REQ-021 EXEC JMP (6): PC<=X -> FETCH.
REQ-022 EXEC JZ (7) / JNZ (C) / JC (D): PC<=X if ACC==0 / ACC!=0 / carry==1, else PC unchanged -> FETCH.
REQ-023 EXEC LOADI (8): ACC<=zero-extended X, carry unchanged -> FETCH.
REQ-024 EXEC HALT (9): -> HALT; HALT is absorbing until rst; halted=1, MAR=0, RAMWr=0.
REQ-025 Opcodes E, F: NOP, -> FETCH, no register change besides PC increment from DECODE.
REQ-026 Outside STORE-EXEC: RAMWr=0, MDRIn=0; MAR=0 in states not listed as driving it.
REQ-027 Latency: memory-operand ops 4 cycles, STORE/jump/LOADI/NOP 3 cycles, HALT reached 3 cycles after FETCH of HALT.
REQ-028 Jump to own address (self-loop) SHALL run indefinitely without hazard; PC-relative wrap never raises a flag.

Reset
REQ-029 rst high asynchronously forces state=FETCH, PC=0, IR=0, ACC=0, carry=0, halted=0 without waiting for clk.
REQ-030 While rst high: MAR=0, RAMWr=0, MDRIn=0; a STORE in progress SHALL be aborted (no write at the next edge).
REQ-031 First FETCH occurs on the first rising edge after rst deasserts; no instruction is partially retired across reset.

Verification
REQ-032 mem[0]=LOAD 50, [1]=ADD 51, [2]=STORE 52, [3]=HALT, mem50=5, mem51=10 -> mem52=15, halted=1 on 14th edge after reset release, PC=4.
REQ-033 Same program with MUL 51 -> mem52=50, carry=0; with mem50=40, mem51=30 -> mem52=176, carry=1.
REQ-034 LOADI 63 (default widths); ADD of word 1023 from memory -> ACC=62, carry=1; JC 20 taken -> PC=20; following SUB of value 62 -> ACC=0, zero=1, carry=0, JNZ not taken.
REQ-035 NOP at address 63 -> next FETCH at address 0 with MAR=0.
REQ-036 rst asserted mid-cycle during STORE EXEC -> RAMWr falls immediately, target word unchanged, PC=0, ACC=0, halted=0; program restarts correctly after release.
